// File: rtl/ysyx_25040105_fetch_unit_if.sv
// Bundle of the fetch unit's memory-request, memory-response, decode-output
// and redirect signals. The master modport is the fetch unit's view; the
// slave modport is the view of the surrounding memory / IDU / EXU.
interface ysyx_25040105_fetch_unit_if;
    // Instruction memory request channel
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    // Instruction memory response channel (no back-pressure)
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    // Buffer head toward the IDU
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_fault;
    // Control-flow redirect from the EXU
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid, imem_resp_data, imem_resp_err,
        output out_valid, out_inst, out_pc, out_fault,
        input  out_ready,
        input  redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid, imem_resp_data, imem_resp_err,
        input  out_valid, out_inst, out_pc, out_fault,
        output out_ready,
        output redirect_valid, redirect_pc
    );
endinterface

// File: rtl/ysyx_25040105_fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, keeps at most one memory
// request outstanding, and buffers returned words in a small FIFO feeding
// decode. A redirect flushes the FIFO and marks any in-flight response stale.
module ysyx_25040105_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    ysyx_25040105_fetch_unit_if.master    bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [0:0] S_REQ  = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]       r_state;
    logic [31:0]      r_pc;
    logic [31:0]      r_pending_pc;
    logic             r_stale;
    logic [31:0]      r_inst_mem  [DEPTH];
    logic [31:0]      r_pc_mem    [DEPTH];
    logic             r_fault_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic        w_out_valid;
    logic        w_req_fire;
    logic        w_resp_take;
    logic        w_push;
    logic        w_pop;
    logic [31:0] w_redirect_pc;
    logic [1:0]  w_unused_redirect_lsb;

    // The two low bits of the redirect target are architecturally ignored.
    assign w_redirect_pc         = {bus.redirect_pc[31:2], 2'b00};
    assign w_unused_redirect_lsb = bus.redirect_pc[1:0];

    // Request only with a guaranteed free slot; held low while reset is asserted.
    assign bus.imem_req_valid = rst & (r_state == S_REQ) & (r_count < FULL_CNT);
    assign bus.imem_req_addr  = r_pc;

    assign w_req_fire  = bus.imem_req_valid & bus.imem_req_ready;
    assign w_resp_take = (r_state == S_WAIT) & bus.imem_resp_valid;
    assign w_push      = w_resp_take & ~r_stale & ~bus.redirect_valid;
    assign w_out_valid = (r_count != '0);
    assign w_pop       = w_out_valid & bus.out_ready & ~bus.redirect_valid;

    // Head of buffer; data fields are forced to zero when nothing is valid.
    assign bus.out_valid = w_out_valid;
    assign bus.out_inst  = w_out_valid ? r_inst_mem[r_rd_ptr]  : 32'h0;
    assign bus.out_pc    = w_out_valid ? r_pc_mem[r_rd_ptr]    : 32'h0;
    assign bus.out_fault = w_out_valid ? r_fault_mem[r_rd_ptr] : 1'b0;

    // Fetch control: PC, request/wait state and stale-response tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_REQ;
            r_pc         <= RESET_PC;
            r_pending_pc <= 32'h0;
            r_stale      <= 1'b0;
        end else if (bus.redirect_valid) begin
            r_pc <= w_redirect_pc;
            if (w_req_fire) begin
                // The memory takes this request anyway; its answer must be dropped.
                r_state      <= S_WAIT;
                r_stale      <= 1'b1;
                r_pending_pc <= r_pc;
            end else if ((r_state == S_WAIT) && !bus.imem_resp_valid) begin
                // Keep waiting so the old response is swallowed when it lands.
                r_state <= S_WAIT;
                r_stale <= 1'b1;
            end else begin
                r_state <= S_REQ;
                r_stale <= 1'b0;
            end
        end else if (r_state == S_REQ) begin
            if (w_req_fire) begin
                r_pending_pc <= r_pc;
                r_pc         <= r_pc + 32'd4;
                r_state      <= S_WAIT;
            end
        end else if (bus.imem_resp_valid) begin
            r_stale <= 1'b0;
            r_state <= S_REQ;
        end
    end

    // Buffer storage: write the returned word at the write pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_inst_mem[i]  <= 32'h0;
                r_pc_mem[i]    <= 32'h0;
                r_fault_mem[i] <= 1'b0;
            end
        end else if (w_push) begin
            r_inst_mem[r_wr_ptr]  <= bus.imem_resp_data;
            r_pc_mem[r_wr_ptr]    <= r_pending_pc;
            r_fault_mem[r_wr_ptr] <= bus.imem_resp_err;
        end
    end

    // Buffer bookkeeping; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (bus.redirect_valid) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_25040105_fetch_unit.sv
// Bench for the fetch unit: a table of memory responses is replayed through a
// small memory model, expected IDU outputs go into a scoreboard queue, and a
// negedge monitor pops and compares them. Hand-written sequences cover
// back-pressure, redirects, reset mid-transaction and PC wrap.
module tb_ysyx_25040105_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    typedef struct {
        int unsigned delay;
        logic [31:0] data;
        logic        err;
        logic [31:0] addr;
    } vec_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        fault;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    ysyx_25040105_fetch_unit_if ifc();

    ysyx_25040105_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: every accepted head must match the oldest expectation.
    always @(negedge clk) begin
        if (rst && ifc.out_valid && ifc.out_ready && !ifc.redirect_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out actual_pc=%h required=none", ifc.out_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("OUT pc=%h inst=%h fault=%b", ifc.out_pc, ifc.out_inst, ifc.out_fault);
                chk("out_inst", ifc.out_inst, e.inst);
                chk("out_pc", ifc.out_pc, e.pc);
                chk("out_fault", {31'h0, ifc.out_fault}, {31'h0, e.fault});
            end
        end
    end

    // Wait (bounded) for a request, check its address, and let it handshake.
    task automatic req_hs(input logic [31:0] addr, output int waited, output bit ok);
        int n;
        n = 0;
        ifc.imem_req_ready = 1'b1;
        while (!ifc.imem_req_valid && n < 50) begin
            tick();
            n++;
        end
        waited = n;
        ok = ifc.imem_req_valid;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL req_timeout actual=none required=%h", addr);
            ifc.imem_req_ready = 1'b0;
        end else begin
            $display("REQ addr=%h waited=%0d", ifc.imem_req_addr, n);
            chk("req_addr", ifc.imem_req_addr, addr);
            tick();
            ifc.imem_req_ready = 1'b0;
        end
    endtask

    // Full memory transaction: request, then a response after 'delay' cycles.
    task automatic fetch_one(input logic [31:0] addr, input int unsigned delay,
                             input logic [31:0] data, input logic err, input bit push,
                             output int waited);
        bit ok;
        req_hs(addr, waited, ok);
        if (ok) begin
            repeat (delay - 1) tick();
            ifc.imem_resp_valid = 1'b1;
            ifc.imem_resp_data  = data;
            ifc.imem_resp_err   = err;
            if (push) exp_q.push_back('{data, addr, err});
            tick();
            ifc.imem_resp_valid = 1'b0;
            ifc.imem_resp_data  = 32'h0;
            ifc.imem_resp_err   = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        chk("drain_left", 32'(exp_q.size()), 32'h0);
    endtask

    task automatic redirect(input logic [31:0] pc);
        ifc.redirect_valid = 1'b1;
        ifc.redirect_pc    = pc;
        exp_q.delete();
        tick();
        ifc.redirect_valid = 1'b0;
        $display("REDIRECT pc=%h", pc);
    endtask

    initial begin
        vec_t vecs[6];
        int   w;
        bit   ok;

        vecs[0] = '{1, 32'h0000_0013, 1'b0, 32'h8000_0000};
        vecs[1] = '{1, 32'h0010_0093, 1'b1, 32'h8000_0004};
        vecs[2] = '{1, 32'h0020_0113, 1'b0, 32'h8000_0008};
        vecs[3] = '{1, 32'h0030_0193, 1'b0, 32'h8000_000C};
        vecs[4] = '{1, 32'h0040_0213, 1'b0, 32'h8000_0010};
        vecs[5] = '{1, 32'h0050_0293, 1'b0, 32'h8000_0014};

        checks = 0;
        errors = 0;
        rst = 1'b0;
        ifc.imem_req_ready  = 1'b0;
        ifc.imem_resp_valid = 1'b0;
        ifc.imem_resp_data  = 32'h0;
        ifc.imem_resp_err   = 1'b0;
        ifc.out_ready       = 1'b1;
        ifc.redirect_valid  = 1'b0;
        ifc.redirect_pc     = 32'h0;

        // Reset state
        repeat (3) tick();
        chk("rst_req_valid", {31'h0, ifc.imem_req_valid}, 32'h0);
        chk("rst_out_valid", {31'h0, ifc.out_valid}, 32'h0);
        chk("rst_out_inst", ifc.out_inst, 32'h0);
        chk("rst_out_pc", ifc.out_pc, 32'h0);
        chk("rst_out_fault", {31'h0, ifc.out_fault}, 32'h0);
        rst = 1'b1;
        #1;
        chk("rel_req_valid", {31'h0, ifc.imem_req_valid}, 32'h1);
        chk("rel_req_addr", ifc.imem_req_addr, RESET_PC);

        // Streaming fetch with 1-cycle responses: back-to-back, no gap
        for (int i = 0; i < 6; i++) begin
            fetch_one(vecs[i].addr, vecs[i].delay, vecs[i].data, vecs[i].err, 1'b1, w);
            chk("stream_gap", 32'(w), 32'h0);
        end
        drain();

        // Back-pressure: buffer fills to two entries and fetch stalls
        ifc.out_ready = 1'b0;
        fetch_one(32'h8000_0018, 1, 32'h1111_0001, 1'b0, 1'b1, w);
        fetch_one(32'h8000_001C, 2, 32'h1111_0002, 1'b0, 1'b1, w);
        ifc.imem_req_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("full_req_valid", {31'h0, ifc.imem_req_valid}, 32'h0);
            tick();
        end
        ifc.imem_req_ready = 1'b0;
        chk("full_out_valid", {31'h0, ifc.out_valid}, 32'h1);
        chk("full_head_pc", ifc.out_pc, 32'h8000_0018);
        ifc.out_ready = 1'b1;
        fetch_one(32'h8000_0020, 1, 32'h1111_0003, 1'b0, 1'b1, w);
        drain();

        // Redirect while waiting; the late response must vanish
        req_hs(32'h8000_0024, w, ok);
        redirect(32'h8000_0100);
        chk("stale_req_valid", {31'h0, ifc.imem_req_valid}, 32'h0);
        tick();
        ifc.imem_resp_valid = 1'b1;
        ifc.imem_resp_data  = 32'hDEAD_BEEF;
        tick();
        ifc.imem_resp_valid = 1'b0;
        ifc.imem_resp_data  = 32'h0;
        fetch_one(32'h8000_0100, 1, 32'h2222_0001, 1'b0, 1'b1, w);
        chk("stale_resume_gap", 32'(w), 32'h0);
        drain();

        // Redirect flushes a full buffer, then a redirect coincides with a handshake
        ifc.out_ready = 1'b0;
        fetch_one(32'h8000_0104, 1, 32'h3333_0001, 1'b0, 1'b1, w);
        fetch_one(32'h8000_0108, 1, 32'h3333_0002, 1'b0, 1'b1, w);
        chk("flush_pre_valid", {31'h0, ifc.out_valid}, 32'h1);
        ifc.out_ready = 1'b1;
        redirect(32'h8000_0008);
        chk("flush_out_valid", {31'h0, ifc.out_valid}, 32'h0);
        chk("redir_req_addr", ifc.imem_req_addr, 32'h8000_0008);
        chk("redir_req_valid", {31'h0, ifc.imem_req_valid}, 32'h1);
        ifc.imem_req_ready = 1'b1;
        redirect(32'h8000_0103);
        ifc.imem_req_ready = 1'b0;
        chk("hs_redir_wait", {31'h0, ifc.imem_req_valid}, 32'h0);
        ifc.imem_resp_valid = 1'b1;
        ifc.imem_resp_data  = 32'hBAD0_0001;
        tick();
        ifc.imem_resp_valid = 1'b0;
        ifc.imem_resp_data  = 32'h0;
        fetch_one(32'h8000_0100, 1, 32'h4444_0001, 1'b0, 1'b1, w);
        chk("hs_redir_gap", 32'(w), 32'h0);
        drain();

        // Reset while waiting with a buffered entry
        ifc.out_ready = 1'b0;
        fetch_one(32'h8000_0104, 1, 32'h5555_0001, 1'b0, 1'b1, w);
        req_hs(32'h8000_0108, w, ok);
        chk("pre_rst_out_valid", {31'h0, ifc.out_valid}, 32'h1);
        rst = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_out_valid", {31'h0, ifc.out_valid}, 32'h0);
        chk("mid_rst_req_valid", {31'h0, ifc.imem_req_valid}, 32'h0);
        ifc.out_ready = 1'b1;
        tick();
        rst = 1'b1;
        #1;
        chk("post_rst_req_addr", ifc.imem_req_addr, RESET_PC);
        fetch_one(RESET_PC, 1, 32'h6666_0001, 1'b0, 1'b1, w);
        drain();

        // PC wrap from the top of the address space
        redirect(32'hFFFF_FFFC);
        fetch_one(32'hFFFF_FFFC, 1, 32'h7777_0001, 1'b0, 1'b1, w);
        fetch_one(32'h0000_0000, 1, 32'h7777_0002, 1'b1, 1'b1, w);
        chk("wrap_next_addr", ifc.imem_req_addr, 32'h0000_0004);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
